// File: rtl/id_pipe_stage_if.sv
// IF-to-ID and ID-to-EX handshake bundle for the decode stage.
// slave is the stage's own view; master is the view of whoever drives IF and EX.
interface id_pipe_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte;
  logic        mem_halfword;
  logic        mem_ex_sel;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic        ex_portb_sel;
  logic        branch_op;
  logic        syscall_op;
  logic        break_op;
  logic        illegal_op;

  modport slave (
    input  in_valid, pc, instruction, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, reg_write, mem_read,
           mem_write, mem_byte, mem_halfword, mem_ex_sel, alu_op, imm,
           ex_portb_sel, branch_op, syscall_op, break_op, illegal_op
  );

  modport master (
    output in_valid, pc, instruction, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, reg_write, mem_read,
           mem_write, mem_byte, mem_halfword, mem_ex_sel, alu_op, imm,
           ex_portb_sel, branch_op, syscall_op, break_op, illegal_op
  );
endinterface

// File: rtl/id_pipe_stage.sv
// RV32 decode stage: decodes on accept and buffers decoded bundles in a DEPTH-entry FIFO.
// Outputs come only from FIFO storage and read as zero while the FIFO is empty.
module id_pipe_stage #(
  parameter int DEPTH = 2,
  parameter int RV32E = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  id_pipe_stage_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_halfword;
    logic        mem_ex_sel;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        portb_sel;
    logic        branch_op;
    logic        syscall_op;
    logic        break_op;
    logic        illegal_op;
  } bundle_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_known, w_bad_f7, w_use_rs1, w_use_rs2, w_use_rd, w_rv32e_bad, w_illegal;
  bundle_t     w_raw, w_dec, w_head;
  bundle_t     r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic        w_in_ready, w_out_valid, w_push, w_pop;

  assign w_ins    = bus.instruction;
  assign w_opcode = w_ins[6:0];
  assign w_f3     = w_ins[14:12];
  assign w_f7     = w_ins[31:25];
  assign w_imm_i  = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s  = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b  = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u  = {w_ins[31:12], 12'b0};
  assign w_imm_j  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  // Per-opcode field decode before legality is applied
  always_comb begin
    w_raw     = '0;
    w_known   = 1'b1;
    w_bad_f7  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_raw.pc  = bus.pc;
    w_raw.rs1 = w_ins[19:15];
    w_raw.rs2 = w_ins[24:20];
    w_raw.rd  = w_ins[11:7];
    w_raw.portb_sel = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_raw.alu_op    = {w_f7[5], w_f3};
        w_raw.portb_sel = 1'b0;
        w_raw.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
        w_bad_f7  = ((w_f7 != 7'b0000000) && (w_f7 != 7'b0100000)) ||
                    (w_f7[5] && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      end
      OPC_OPIMM: begin
        w_raw.alu_op    = {(w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
        w_raw.imm       = w_imm_i;
        w_raw.rs2       = 5'd0;
        w_raw.reg_write = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OPC_LOAD: begin
        w_raw.imm          = w_imm_i;
        w_raw.rs2          = 5'd0;
        w_raw.reg_write    = 1'b1;
        w_raw.mem_read     = 1'b1;
        w_raw.mem_byte     = (w_f3[1:0] == 2'b00);
        w_raw.mem_halfword = (w_f3[1:0] == 2'b01);
        w_raw.mem_ex_sel   = w_f3[2];
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OPC_STORE: begin
        w_raw.imm          = w_imm_s;
        w_raw.rd           = 5'd0;
        w_raw.mem_write    = 1'b1;
        w_raw.mem_byte     = (w_f3[1:0] == 2'b00);
        w_raw.mem_halfword = (w_f3[1:0] == 2'b01);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        w_raw.alu_op    = 4'b1000;
        w_raw.imm       = w_imm_b;
        w_raw.rd        = 5'd0;
        w_raw.portb_sel = 1'b0;
        w_raw.branch_op = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        w_raw.imm       = w_imm_u;
        w_raw.rs1       = 5'd0;
        w_raw.rs2       = 5'd0;
        w_raw.reg_write = 1'b1;
        w_use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        w_raw.imm       = w_imm_u;
        w_raw.rs2       = 5'd0;
        w_raw.reg_write = 1'b1;
        w_use_rd = 1'b1;
      end
      OPC_JAL: begin
        // JAL reads no source registers; those bit positions hold offset bits
        w_raw.imm       = w_imm_j;
        w_raw.rs1       = 5'd0;
        w_raw.rs2       = 5'd0;
        w_raw.reg_write = 1'b1;
        w_raw.branch_op = 1'b1;
        w_use_rd = 1'b1;
      end
      OPC_JALR: begin
        w_raw.imm       = w_imm_i;
        w_raw.rs2       = 5'd0;
        w_raw.reg_write = 1'b1;
        w_raw.branch_op = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OPC_SYSTEM: begin
        w_raw.imm        = w_imm_i;
        w_raw.rs2        = 5'd0;
        w_raw.syscall_op = (w_ins == 32'h0000_0073);
        w_raw.break_op   = (w_ins == 32'h0010_0073);
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  // Legality check; an illegal word keeps only its PC and the illegal flag
  always_comb begin
    w_rv32e_bad = (RV32E != 0) && ((w_use_rs1 && w_raw.rs1[4]) ||
                                   (w_use_rs2 && w_raw.rs2[4]) ||
                                   (w_use_rd  && w_raw.rd[4]));
    w_illegal   = !w_known || (w_ins[1:0] != 2'b11) || w_bad_f7 || w_rv32e_bad;
    if (w_illegal) begin
      w_dec            = '0;
      w_dec.pc         = bus.pc;
      w_dec.illegal_op = 1'b1;
    end else begin
      w_dec           = w_raw;
      w_dec.reg_write = w_raw.reg_write && (w_raw.rd != 5'd0);
    end
  end

  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != CW'(0));
  assign w_push      = bus.in_valid && w_in_ready && !flush;
  assign w_pop       = w_out_valid && bus.out_ready && !flush;

  // FIFO occupancy and pointers; reset outranks flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Bundle storage; contents are don't-care until counted valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_pc       = w_head.pc;
  assign bus.rs1          = w_head.rs1;
  assign bus.rs2          = w_head.rs2;
  assign bus.rd           = w_head.rd;
  assign bus.reg_write    = w_head.reg_write;
  assign bus.mem_read     = w_head.mem_read;
  assign bus.mem_write    = w_head.mem_write;
  assign bus.mem_byte     = w_head.mem_byte;
  assign bus.mem_halfword = w_head.mem_halfword;
  assign bus.mem_ex_sel   = w_head.mem_ex_sel;
  assign bus.alu_op       = w_head.alu_op;
  assign bus.imm          = w_head.imm;
  assign bus.ex_portb_sel = w_head.portb_sel;
  assign bus.branch_op    = w_head.branch_op;
  assign bus.syscall_op   = w_head.syscall_op;
  assign bus.break_op     = w_head.break_op;
  assign bus.illegal_op   = w_head.illegal_op;
endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: decode vector table on an RV32I and an RV32E
// instance, plus hand-written back-pressure, flush and reset sequences.
module tb_id_pipe_stage;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mb;
    logic        mh;
    logic        mx;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        pb;
    logic        br;
    logic        sys;
    logic        brk;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        use_e;
    dec_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] pc, instruction;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_pipe_stage_if bus0 ();
  id_pipe_stage_if bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.pc = pc;
  assign bus0.instruction = instruction;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;
  assign bus1.pc = pc;
  assign bus1.instruction = instruction;
  assign bus1.out_ready = out_ready;

  id_pipe_stage #(.DEPTH(2), .RV32E(0)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
  id_pipe_stage #(.DEPTH(2), .RV32E(1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));

  function automatic dec_t get0();
    return '{bus0.rs1, bus0.rs2, bus0.rd, bus0.reg_write, bus0.mem_read, bus0.mem_write,
             bus0.mem_byte, bus0.mem_halfword, bus0.mem_ex_sel, bus0.alu_op, bus0.imm,
             bus0.ex_portb_sel, bus0.branch_op, bus0.syscall_op, bus0.break_op, bus0.illegal_op};
  endfunction

  function automatic dec_t get1();
    return '{bus1.rs1, bus1.rs2, bus1.rd, bus1.reg_write, bus1.mem_read, bus1.mem_write,
             bus1.mem_byte, bus1.mem_halfword, bus1.mem_ex_sel, bus1.alu_op, bus1.imm,
             bus1.ex_portb_sel, bus1.branch_op, bus1.syscall_op, bus1.break_op, bus1.illegal_op};
  endfunction

  function automatic dec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [5:0] rwmem, input logic [3:0] alu, input logic [31:0] imm,
                              input logic [4:0] flags);
    dec_t d;
    d = '{rs1, rs2, rd, rwmem[5], rwmem[4], rwmem[3], rwmem[2], rwmem[1], rwmem[0],
          alu, imm, flags[4], flags[3], flags[2], flags[1], flags[0]};
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [18];
  dec_t ill_d;
  dec_t zero_d;

  initial begin
    ill_d  = mk(5'd0, 5'd0, 5'd0, 6'b000000, 4'd0, 32'd0, 5'b00001);
    zero_d = '0;
    //            rs1    rs2    rd     rw mr mw mb mh mx   alu       imm             pb br sys brk ill
    vecs[0]  = '{32'h00510093, 32'h100, 1'b0, mk(5'd2, 5'd0, 5'd1,  6'b100000, 4'b0000, 32'd5,        5'b10000)};
    vecs[1]  = '{32'h00824183, 32'h104, 1'b0, mk(5'd4, 5'd0, 5'd3,  6'b110101, 4'b0000, 32'd8,        5'b10000)};
    vecs[2]  = '{32'h00000073, 32'h108, 1'b0, mk(5'd0, 5'd0, 5'd0,  6'b000000, 4'b0000, 32'd0,        5'b10100)};
    vecs[3]  = '{32'h00100073, 32'h10C, 1'b0, mk(5'd0, 5'd0, 5'd0,  6'b000000, 4'b0000, 32'd1,        5'b10010)};
    vecs[4]  = '{32'hFFFFFFFF, 32'h110, 1'b0, ill_d};
    vecs[5]  = '{32'h002088B3, 32'h114, 1'b0, mk(5'd1, 5'd2, 5'd17, 6'b100000, 4'b0000, 32'd0,        5'b00000)};
    vecs[6]  = '{32'h002088B3, 32'h114, 1'b1, ill_d};
    vecs[7]  = '{32'h00510093, 32'h118, 1'b1, mk(5'd2, 5'd0, 5'd1,  6'b100000, 4'b0000, 32'd5,        5'b10000)};
    vecs[8]  = '{32'h407302B3, 32'h11C, 1'b0, mk(5'd6, 5'd7, 5'd5,  6'b100000, 4'b1000, 32'd0,        5'b00000)};
    vecs[9]  = '{32'h02000033, 32'h120, 1'b0, ill_d};
    vecs[10] = '{32'h40006033, 32'h124, 1'b0, ill_d};
    vecs[11] = '{32'hFE512E23, 32'h128, 1'b0, mk(5'd2, 5'd5, 5'd0,  6'b001000, 4'b0000, 32'hFFFFFFFC, 5'b10000)};
    vecs[12] = '{32'hFE208CE3, 32'h12C, 1'b0, mk(5'd1, 5'd2, 5'd0,  6'b000000, 4'b1000, 32'hFFFFFFF8, 5'b01000)};
    vecs[13] = '{32'h12345537, 32'h130, 1'b0, mk(5'd0, 5'd0, 5'd10, 6'b100000, 4'b0000, 32'h12345000, 5'b10000)};
    vecs[14] = '{32'h00008067, 32'h134, 1'b0, mk(5'd1, 5'd0, 5'd0,  6'b000000, 4'b0000, 32'd0,        5'b11000)};
    vecs[15] = '{32'h4030D093, 32'h138, 1'b0, mk(5'd1, 5'd0, 5'd1,  6'b100000, 4'b1101, 32'h403,      5'b10000)};
    vecs[16] = '{32'h00239303, 32'h13C, 1'b0, mk(5'd7, 5'd0, 5'd6,  6'b110010, 4'b0000, 32'd2,        5'b10000)};
    vecs[17] = '{32'h00510091, 32'h140, 1'b0, ill_d};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc = 32'h0; instruction = 32'h0;
    tick(); tick();
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_dec", 64'(get0()), 64'(zero_d));
    chk("rst_out_pc", 64'(bus0.out_pc), 64'd0);
    rst_n = 1'b1;
    tick();

    // decode table: push into an empty FIFO, check the head after one edge, then pop it
    for (int i = 0; i < 18; i++) begin
      pc = vecs[i].pc; instruction = vecs[i].instr; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vecs[i].use_e) begin
        chk($sformatf("vec%0d_dec_e", i), 64'(get1()), 64'(vecs[i].exp));
        chk($sformatf("vec%0d_pc_e", i), 64'(bus1.out_pc), 64'(vecs[i].pc));
      end else begin
        chk($sformatf("vec%0d_dec", i), 64'(get0()), 64'(vecs[i].exp));
        chk($sformatf("vec%0d_pc", i), 64'(bus0.out_pc), 64'(vecs[i].pc));
      end
      chk($sformatf("vec%0d_valid", i), 64'(bus0.out_valid), 64'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), 64'(bus0.out_valid), 64'd0);
    end

    // back-pressure: three pushes into a two-deep FIFO with EX stalled
    instruction = 32'h00510093;
    pc = 32'h200; in_valid = 1'b1;
    tick();
    chk("bp_ready_after1", 64'(bus0.in_ready), 64'd1);
    pc = 32'h204;
    tick();
    chk("bp_ready_after2", 64'(bus0.in_ready), 64'd0);
    pc = 32'h208;
    tick();
    chk("bp_held", 64'(bus0.in_ready), 64'd0);
    chk("bp_head_a", 64'(bus0.out_pc), 64'h200);
    out_ready = 1'b1;
    #1;
    chk("bp_no_comb_ready", 64'(bus0.in_ready), 64'd0);
    tick();
    chk("bp_head_b", 64'(bus0.out_pc), 64'h204);
    chk("bp_ready_again", 64'(bus0.in_ready), 64'd1);
    tick();
    chk("bp_head_c", 64'(bus0.out_pc), 64'h208);
    chk("bp_valid_c", 64'(bus0.out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 64'(bus0.out_valid), 64'd0);
    out_ready = 1'b0;

    // flush with two entries buffered and a third word on the input
    in_valid = 1'b1; pc = 32'h300;
    tick();
    pc = 32'h304;
    tick();
    pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(bus0.out_valid), 64'd0);
    chk("fl_ready", 64'(bus0.in_ready), 64'd1);
    chk("fl_dec_zero", 64'(get0()), 64'(zero_d));
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_ghost", 64'(bus0.out_valid), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; pc = 32'h30C; instruction = 32'h00824183;
    tick();
    in_valid = 1'b0;
    chk("fl_next_pc", 64'(bus0.out_pc), 64'h30C);
    chk("fl_next_dec", 64'(get0()), 64'(vecs[1].exp));

    // reset mid-stream drops the buffered entry
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 64'(bus0.out_valid), 64'd0);
    chk("mrst_ready", 64'(bus0.in_ready), 64'd1);
    chk("mrst_pc", 64'(bus0.out_pc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
